// File: rtl/bg_mode_sequencer.sv
// Play-mode background colour sequencer.
// Chooses the RRRGGGBB background word for each game phase (menu, play,
// hit-flash, level-transition fade, game-over). Frame counters advance only
// on startOfFrame, so an effect never changes in the middle of a frame.
//
// Interface semantics: there is no valid/ready handshake here. All event
// inputs are strobes sampled on every clk edge. BG_COLOR is registered from
// the registered state/counters, so it lags a state change by one clk.
// bgState and busy are registered together with the state.
module bg_mode_sequencer #(
   parameter int unsigned FLASH_FRAMES     = 16,
   parameter int unsigned FLASH_PERIOD     = 4,
   parameter int unsigned FADE_STEP_FRAMES = 8,
   parameter logic [7:0]  MENU_COLOR       = 8'b000_000_00,
   parameter logic [7:0]  PLAY_COLOR       = 8'b100_000_00,
   parameter logic [7:0]  FLASH_COLOR      = 8'b111_111_11,
   parameter logic [7:0]  OVER_COLOR       = 8'b010_000_01
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic       gameStart,
   input  logic       playerHit,
   input  logic       levelDone,
   input  logic       gameOver,
   output logic [7:0] BG_COLOR,
   output logic [2:0] bgState,
   output logic       busy
);

   // The frame counter must reach the larger of the two episode lengths
   // minus one without wrapping.
   localparam int unsigned CNT_MAX = (FLASH_FRAMES > FADE_STEP_FRAMES) ?
                                     FLASH_FRAMES : FADE_STEP_FRAMES;
   localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_FRAMES - 1);
   localparam logic [CNT_W-1:0] FADE_LAST   = CNT_W'(FADE_STEP_FRAMES - 1);
   localparam logic [CNT_W-1:0] FLASH_HALF  = CNT_W'(FLASH_PERIOD);

   localparam logic       DIR_DOWN = 1'b0;
   localparam logic       DIR_UP   = 1'b1;
   localparam logic [2:0] LVL_MAX  = 3'd7;
   localparam logic [2:0] LVL_MIN  = 3'd0;

   typedef enum logic [2:0] {
      S_MENU  = 3'd0,
      S_PLAY  = 3'd1,
      S_FLASH = 3'd2,
      S_FADE  = 3'd3,
      S_OVER  = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [2:0]       fade_lvl_q, fade_lvl_d;
   logic             fade_dir_q, fade_dir_d;
   logic             busy_q, busy_d;
   logic [7:0]       color_q, color_d;

   // Helpers for the colour path.
   logic [CNT_W-1:0] flash_half_idx;
   logic             flash_on;
   logic [2:0]       fade_r, fade_g;
   logic [1:0]       fade_b;

   // Clamp a colour channel to the current fade level.
   function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
      return (a < b) ? a : b;
   endfunction

   // Next-state logic: event priority gameOver > playerHit > levelDone >
   // gameStart; a state-changing event always beats a coincident frame strobe.
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      fade_lvl_d  = fade_lvl_q;
      fade_dir_d  = fade_dir_q;

      case (state_q)
         S_MENU: begin
            if (gameStart) begin
               state_d     = S_PLAY;
               frame_cnt_d = '0;
            end
         end

         S_PLAY: begin
            if (gameOver) begin
               state_d     = S_OVER;
               frame_cnt_d = '0;
            end else if (playerHit) begin
               state_d     = S_FLASH;
               frame_cnt_d = '0;
            end else if (levelDone) begin
               state_d     = S_FADE;
               frame_cnt_d = '0;
               fade_lvl_d  = LVL_MAX;
               fade_dir_d  = DIR_DOWN;
            end
         end

         S_FLASH: begin
            if (gameOver) begin
               state_d     = S_OVER;
               frame_cnt_d = '0;
            end else if (playerHit) begin
               // A new hit restarts the whole episode from flash-on.
               frame_cnt_d = '0;
            end else if (startOfFrame) begin
               if (frame_cnt_q == FLASH_LAST) begin
                  state_d     = S_PLAY;
                  frame_cnt_d = '0;
               end else begin
                  frame_cnt_d = frame_cnt_q + 1'b1;
               end
            end
         end

         S_FADE: begin
            if (gameOver) begin
               state_d     = S_OVER;
               frame_cnt_d = '0;
            end else if (startOfFrame) begin
               if (frame_cnt_q == FADE_LAST) begin
                  frame_cnt_d = '0;
                  if (fade_dir_q == DIR_DOWN) begin
                     // Descend; turn around on reaching the bottom level.
                     if (fade_lvl_q != LVL_MIN) begin
                        fade_lvl_d = fade_lvl_q - 1'b1;
                     end
                     if (fade_lvl_q <= 3'd1) begin
                        fade_dir_d = DIR_UP;
                     end
                  end else begin
                     // Ascend; the fade is complete on reaching the top level.
                     if (fade_lvl_q != LVL_MAX) begin
                        fade_lvl_d = fade_lvl_q + 1'b1;
                     end
                     if (fade_lvl_q >= 3'd6) begin
                        state_d    = S_PLAY;
                        fade_dir_d = DIR_DOWN;
                     end
                  end
               end else begin
                  frame_cnt_d = frame_cnt_q + 1'b1;
               end
            end
         end

         S_OVER: begin
            if (gameStart) begin
               state_d     = S_PLAY;
               frame_cnt_d = '0;
               fade_lvl_d  = LVL_MAX;
               fade_dir_d  = DIR_DOWN;
            end
         end

         default: begin
            state_d     = S_MENU;
            frame_cnt_d = '0;
            fade_lvl_d  = LVL_MAX;
            fade_dir_d  = DIR_DOWN;
         end
      endcase

      busy_d = (state_d == S_FLASH) || (state_d == S_FADE);
   end

   // Colour selection from the registered state, so the colour follows the
   // state by exactly one clk.
   always_comb begin
      flash_half_idx = frame_cnt_q / FLASH_HALF;
      flash_on       = ~flash_half_idx[0];
      fade_r         = min3(PLAY_COLOR[7:5], fade_lvl_q);
      fade_g         = min3(PLAY_COLOR[4:2], fade_lvl_q);
      fade_b         = min2(PLAY_COLOR[1:0], fade_lvl_q[2:1]);
      color_d        = MENU_COLOR;

      case (state_q)
         S_MENU:  color_d = MENU_COLOR;
         S_PLAY:  color_d = PLAY_COLOR;
         S_FLASH: color_d = flash_on ? FLASH_COLOR : PLAY_COLOR;
         S_FADE:  color_d = {fade_r, fade_g, fade_b};
         S_OVER:  color_d = OVER_COLOR;
         default: color_d = MENU_COLOR;
      endcase
   end

   // State, counters, busy and colour registers.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= S_MENU;
         frame_cnt_q <= '0;
         fade_lvl_q  <= LVL_MAX;
         fade_dir_q  <= DIR_DOWN;
         busy_q      <= 1'b0;
         color_q     <= MENU_COLOR;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         fade_lvl_q  <= fade_lvl_d;
         fade_dir_q  <= fade_dir_d;
         busy_q      <= busy_d;
         color_q     <= color_d;
      end
   end

   assign BG_COLOR = color_q;
   assign bgState  = state_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_bg_mode_sequencer.sv
// Bench for bg_mode_sequencer: directed stimulus with hand-computed
// expectations pushed into a queue; a monitor pops and compares the packed
// {busy, bgState, BG_COLOR} word on the falling edge.
module tb_bg_mode_sequencer;

   logic       clk = 1'b0;
   logic       resetN;
   logic       startOfFrame;
   logic       gameStart;
   logic       playerHit;
   logic       levelDone;
   logic       gameOver;
   logic [7:0] BG_COLOR;
   logic [2:0] bgState;
   logic       busy;

   logic [11:0] exp_q[$];
   string       tag_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   localparam logic [7:0] C_MENU  = 8'h00;
   localparam logic [7:0] C_PLAY  = 8'h80;
   localparam logic [7:0] C_FLASH = 8'hFF;
   localparam logic [7:0] C_OVER  = 8'h41;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   bg_mode_sequencer dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .gameStart    (gameStart),
      .playerHit    (playerHit),
      .levelDone    (levelDone),
      .gameOver     (gameOver),
      .BG_COLOR     (BG_COLOR),
      .bgState      (bgState),
      .busy         (busy)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, %0d checks pending", exp_q.size());
      $fatal(1, "watchdog");
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [11:0] exp_v;
         logic [11:0] act_v;
         string       tag;
         exp_v = exp_q.pop_front();
         tag   = tag_q.pop_front();
         act_v = {busy, bgState, BG_COLOR};
         n_checks++;
         if (act_v === exp_v) begin
            n_pass++;
         end else begin
            $display("FAIL %s: got busy=%b state=%0d color=%h, expected busy=%b state=%0d color=%h",
                     tag, act_v[11], act_v[10:8], act_v[7:0],
                     exp_v[11], exp_v[10:8], exp_v[7:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_now(input string tag, input logic b, input logic [2:0] st,
                            input logic [7:0] col);
      exp_q.push_back({b, st, col});
      tag_q.push_back(tag);
      @(negedge clk);
      #1;
   endtask

   task automatic pulse(input logic sof, input logic gs, input logic ph,
                        input logic ld, input logic go);
      startOfFrame = sof;
      gameStart    = gs;
      playerHit    = ph;
      levelDone    = ld;
      gameOver     = go;
      tick();
      startOfFrame = 1'b0;
      gameStart    = 1'b0;
      playerHit    = 1'b0;
      levelDone    = 1'b0;
      gameOver     = 1'b0;
   endtask

   // One frame strobe, then one idle clk so the registered colour has caught up.
   task automatic frame_chk(input string tag, input logic b, input logic [2:0] st,
                            input logic [7:0] col);
      pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check_now(tag, b, st, col);
   endtask

   // Expected flash colour for frame index k within an episode.
   function automatic logic [7:0] flash_exp(input int k);
      return (((k / 4) % 2) == 0) ? C_FLASH : C_PLAY;
   endfunction

   // Expected fade colour after s completed 8-frame steps (s < 14).
   function automatic logic [7:0] fade_exp(input int s);
      int lvl;
      int r;
      lvl = (s <= 7) ? (7 - s) : (s - 7);
      r   = (lvl < 4) ? lvl : 4;
      return {r[2:0], 5'b00000};
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      resetN       = 1'b0;
      startOfFrame = 1'b0;
      gameStart    = 1'b0;
      playerHit    = 1'b0;
      levelDone    = 1'b0;
      gameOver     = 1'b0;
      tick();
      tick();
      check_now("reset_state", 1'b0, 3'd0, C_MENU);
      resetN = 1'b1;
      tick();

      // Menu ignores everything except gameStart.
      pulse(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      check_now("menu_ignore", 1'b0, 3'd0, C_MENU);

      // 1. Start game: state changes first, colour one clk later.
      pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_now("start_state", 1'b0, 3'd1, C_MENU);
      tick();
      check_now("start_color", 1'b0, 3'd1, C_PLAY);

      // 2. Hit flash: 16 frames, FF x4 / 80 x4 pattern, then PLAY.
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_now("hit_state", 1'b1, 3'd2, C_PLAY);
      tick();
      check_now("flash_f0", 1'b1, 3'd2, C_FLASH);
      for (int k = 1; k < 16; k++) begin
         frame_chk($sformatf("flash_f%0d", k), 1'b1, 3'd2, flash_exp(k));
      end
      frame_chk("flash_end", 1'b0, 3'd1, C_PLAY);

      // 3. Restart the flash at frame 10; a coincident frame strobe and
      //    ignored events must not add a step.
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      for (int k = 1; k <= 10; k++) begin
         frame_chk($sformatf("flash2_f%0d", k), 1'b1, 3'd2, flash_exp(k));
      end
      pulse(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      check_now("restart_f0", 1'b1, 3'd2, C_FLASH);
      for (int k = 1; k < 16; k++) begin
         frame_chk($sformatf("restart_f%0d", k), 1'b1, 3'd2, flash_exp(k));
      end
      frame_chk("restart_end", 1'b0, 3'd1, C_PLAY);

      // 4. Level fade: red field 4,4,4,4,3,2,1,0,1,2,3,4,4,4; PLAY after 112.
      pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check_now("fade_f0", 1'b1, 3'd3, C_PLAY);
      for (int f = 1; f <= 112; f++) begin
         if (f == 20) begin
            // playerHit and levelDone are ignored during the fade.
            pulse(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            tick();
            check_now("fade_ignore", 1'b1, 3'd3, fade_exp(f / 8));
         end else if (f == 112) begin
            frame_chk("fade_end", 1'b0, 3'd1, C_PLAY);
         end else begin
            frame_chk($sformatf("fade_f%0d", f), 1'b1, 3'd3, fade_exp(f / 8));
         end
      end

      // 5. gameOver beats a simultaneous playerHit.
      pulse(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      check_now("over_prio", 1'b0, 3'd4, C_OVER);
      pulse(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      check_now("over_ignore", 1'b0, 3'd4, C_OVER);
      pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check_now("over_restart", 1'b0, 3'd1, C_PLAY);

      // 6. Asynchronous reset in the middle of a fade.
      pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      for (int f = 1; f <= 10; f++) begin
         frame_chk($sformatf("fade2_f%0d", f), 1'b1, 3'd3, fade_exp(f / 8));
      end
      tick();
      resetN = 1'b0;
      check_now("async_reset", 1'b0, 3'd0, C_MENU);
      resetN = 1'b1;
      tick();
      frame_chk("post_reset_sof", 1'b0, 3'd0, C_MENU);

      // Every pushed expectation must have been consumed.
      tick();
      n_checks++;
      if (exp_q.size() == 0) begin
         n_pass++;
      end else begin
         $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
